datamem_arb: RTL and testbench

Two-port arbiter that shares the single-ported byte-addressed data memory between two word-access requesters: port 0 is the processor data port, port 1 is the checker/DMA port. It sequences one word access per grant, drives the memory's address/write-enable/write-data port, registers the read word, and returns a per-port ack or error. It sits directly in front of the data memory; nothing else drives the memory port.

---
 rtl/datamem_arb_pkg.sv | 22 ++
 rtl/datamem_arb_if.sv | 23 ++
 rtl/datamem_arb_rr_arb2.sv | 24 ++
 rtl/datamem_arb.sv | 124 ++++++++++++
 tb/tb_datamem_arb.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/datamem_arb_pkg.sv
// datamem_pkg: shared definitions for the data-memory arbiter.
//   DEFAULT_WORD_WIDTH / DEFAULT_MEM_DEPTH : parameter defaults
//   state_t                                 : arbiter FSM states
//   addr_bad()                              : word alignment and range check
package datamem_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;
  localparam int DEFAULT_MEM_DEPTH  = 1024;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  // A word access is rejected when it is not word aligned or when its last
  // byte would fall past the end of memory.
  function automatic logic addr_bad(input logic [DEFAULT_WORD_WIDTH-1:0] addr,
                                    input int unsigned                   depth);
    return (addr[1:0] != 2'b00) || (addr > (depth - 32'd4));
  endfunction

endpackage

// File: rtl/datamem_arb_if.sv
// datamem_arb_if: one requester's word-access handshake.
//   req   : access request, held until ack
//   wr    : 1 = write, 0 = read
//   addr  : byte address
//   wdata : write word, big-endian
//   ack   : one-cycle completion pulse
//   err   : access rejected, valid with ack
//   rdata : read word, valid with ack
// master = requester side, slave = arbiter side.
interface datamem_arb_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  req;
  logic                  wr;
  logic [WORD_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] wdata;
  logic                  ack;
  logic                  err;
  logic [WORD_WIDTH-1:0] rdata;

  modport master (output req, wr, addr, wdata, input ack, err, rdata);
  modport slave  (input req, wr, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/datamem_arb_rr_arb2.sv
// rr_arb2: combinational two-requester round-robin picker.
//   eligible  : bit p set when port p may be granted
//   last_gnt  : port granted most recently
//   gnt_valid : some port is eligible
//   gnt_idx   : winning port
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // On a tie the port that did not win last time goes next; otherwise the
  // lone eligible port wins (index 1 exactly when only bit 1 is set).
  always_comb begin
    gnt_valid = |eligible;
    if (&eligible) begin
      gnt_idx = ~last_gnt;
    end else begin
      gnt_idx = eligible[1];
    end
  end

endmodule

// File: rtl/datamem_arb.sv
// datamem_arb: shares a single-ported byte-addressed data memory between the
// processor data port (m0) and the checker/DMA port (m1), one word access per
// grant.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   m0, m1     : requester handshakes (datamem_arb_if.slave)
//   data_addr  : memory byte address
//   data_wr    : memory write enable, memory writes on the rising edge
//   data_out   : memory write word
//   data_in    : memory read word, combinational from data_addr
module datamem_arb
  import datamem_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  datamem_arb_if.slave          m0,
  datamem_arb_if.slave          m1,
  output logic [WORD_WIDTH-1:0] data_addr,
  output logic                  data_wr,
  output logic [WORD_WIDTH-1:0] data_out,
  input  logic [WORD_WIDTH-1:0] data_in
);

  state_t                state;
  state_t                state_next;
  logic                  last_gnt;
  logic                  cmd_wr;
  logic [WORD_WIDTH-1:0] cmd_addr;
  logic [WORD_WIDTH-1:0] cmd_wdata;
  logic [1:0]            eligible;
  logic                  gnt_valid;
  logic                  gnt_idx;
  logic                  bad;
  logic [WORD_WIDTH-1:0] rd_word;

  // A port whose ack is out this cycle is still holding req; mask it so the
  // stale request is not granted a second time.
  assign eligible = {m1.req & ~m1.ack, m0.req & ~m0.ack};

  rr_arb2 u_rr_arb2 (
    .eligible  (eligible),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign bad     = addr_bad(cmd_addr, MEM_DEPTH);
  assign rd_word = (!cmd_wr && !bad) ? data_in : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (gnt_valid) state_next = ACCESS;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // last_gnt doubles as the port owning the command during ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (state == IDLE && gnt_valid) begin
      last_gnt  <= gnt_idx;
      cmd_wr    <= gnt_idx ? m1.wr    : m0.wr;
      cmd_addr  <= gnt_idx ? m1.addr  : m0.addr;
      cmd_wdata <= gnt_idx ? m1.wdata : m0.wdata;
    end
  end

  // Completion is registered at the end of ACCESS; rdata holds between acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0.ack   <= 1'b0;
      m0.err   <= 1'b0;
      m0.rdata <= '0;
      m1.ack   <= 1'b0;
      m1.err   <= 1'b0;
      m1.rdata <= '0;
    end else begin
      m0.ack <= 1'b0;
      m0.err <= 1'b0;
      m1.ack <= 1'b0;
      m1.err <= 1'b0;
      if (state == ACCESS) begin
        if (last_gnt) begin
          m1.ack   <= 1'b1;
          m1.err   <= bad;
          m1.rdata <= rd_word;
        end else begin
          m0.ack   <= 1'b1;
          m0.err   <= bad;
          m0.rdata <= rd_word;
        end
      end
    end
  end

  // rst gates the write enable so a reset landing in ACCESS commits nothing.
  always_comb begin
    data_wr   = 1'b0;
    data_addr = '0;
    data_out  = '0;
    if (state == ACCESS) begin
      data_wr   = cmd_wr && !bad && !rst;
      data_addr = cmd_addr;
      data_out  = cmd_wdata;
    end
  end

endmodule

// File: tb/tb_datamem_arb.sv
module tb_datamem_arb;
  import datamem_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_addr;
  logic         data_wr;
  logic [W-1:0] data_out;
  logic [W-1:0] data_in;

  always #5 clk = ~clk;

  datamem_arb_if #(.WORD_WIDTH(W)) m0_bus ();
  datamem_arb_if #(.WORD_WIDTH(W)) m1_bus ();

  datamem_arb #(.WORD_WIDTH(W), .MEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .data_addr (data_addr),
    .data_wr   (data_wr),
    .data_out  (data_out),
    .data_in   (data_in)
  );

  // Byte-addressed big-endian memory model, byte i preloaded with i[7:0].
  logic [7:0]   mem [DEPTH];
  logic         mem_loaded = 1'b0;
  int           wr_count = 0;
  logic [W-1:0] last_wr_addr = '0;

  always_comb begin
    data_in = '0;
    if (data_addr <= W'(DEPTH - 4))
      data_in = {mem[data_addr[9:0]], mem[data_addr[9:0] + 10'd1],
                 mem[data_addr[9:0] + 10'd2], mem[data_addr[9:0] + 10'd3]};
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
      mem_loaded <= 1'b1;
    end else if (data_wr) begin
      mem[data_addr[9:0]]         <= data_out[31:24];
      mem[data_addr[9:0] + 10'd1] <= data_out[23:16];
      mem[data_addr[9:0] + 10'd2] <= data_out[15:8];
      mem[data_addr[9:0] + 10'd3] <= data_out[7:0];
      wr_count     <= wr_count + 1;
      last_wr_addr <= data_addr;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic         port;
    logic         err;
    logic [W-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ack_count = 0;
  int   prev_ack_cyc = 0;
  bit   have_prev = 1'b0;
  bit   spacing_on = 1'b0;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timeout waiting for ack", name);
  endtask

  // Scoreboard monitor: every ack pops one expected completion.
  task automatic handleAck(input logic port, input logic err, input logic [W-1:0] rdata,
                           input logic other_ack);
    exp_t e;
    ack_count++;
    checkOutput("single_ack", W'(other_ack), W'(0));
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_ack port=%0d actual=1 required=0", port);
    end else begin
      e = exp_q.pop_front();
      checkOutput("ack_port", W'(port), W'(e.port));
      checkOutput("ack_err", W'(err), W'(e.err));
      checkOutput("ack_rdata", rdata, e.rdata);
    end
    if (spacing_on && have_prev) checkOutput("ack_spacing", W'(cyc - prev_ack_cyc), W'(2));
    prev_ack_cyc = cyc;
    have_prev = 1'b1;
  endtask

  always @(negedge clk) begin
    if (m0_bus.ack) handleAck(1'b0, m0_bus.err, m0_bus.rdata, m1_bus.ack);
    if (m1_bus.ack) handleAck(1'b1, m1_bus.err, m1_bus.rdata, m0_bus.ack);
  end

  task automatic applyStimulus(input logic port, input logic wr, input logic [W-1:0] addr,
                               input logic [W-1:0] wdata);
    if (!port) begin
      m0_bus.wr = wr; m0_bus.addr = addr; m0_bus.wdata = wdata; m0_bus.req = 1'b1;
    end else begin
      m1_bus.wr = wr; m1_bus.addr = addr; m1_bus.wdata = wdata; m1_bus.req = 1'b1;
    end
  endtask

  task automatic releasePort(input logic port);
    if (!port) m0_bus.req = 1'b0;
    else       m1_bus.req = 1'b0;
  endtask

  task automatic waitAck(input logic port, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? m1_bus.ack : m0_bus.ack;
    end
  endtask

  task automatic pushExp(input logic port, input logic err, input logic [W-1:0] rdata);
    exp_t e;
    e.port = port; e.err = err; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // One complete access: request, expect ack two cycles later, drop req after ack.
  task automatic doAccess(input string name, input logic port, input logic wr,
                          input logic [W-1:0] addr, input logic [W-1:0] wdata,
                          input logic exp_err, input logic [W-1:0] exp_rdata);
    int start;
    bit got;
    @(posedge clk); #1;
    pushExp(port, exp_err, exp_rdata);
    applyStimulus(port, wr, addr, wdata);
    start = cyc;
    waitAck(port, got);
    if (!got) reportTimeout(name);
    else checkOutput({name, "_latency"}, W'(cyc - start), W'(2));
    @(posedge clk); #1;
    releasePort(port);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_m0_ack"}, W'(m0_bus.ack), W'(0));
    checkOutput({tag, "_m1_ack"}, W'(m1_bus.ack), W'(0));
    checkOutput({tag, "_m0_err"}, W'(m0_bus.err), W'(0));
    checkOutput({tag, "_m1_err"}, W'(m1_bus.err), W'(0));
    checkOutput({tag, "_m0_rdata"}, m0_bus.rdata, W'(0));
    checkOutput({tag, "_m1_rdata"}, m1_bus.rdata, W'(0));
    checkOutput({tag, "_data_wr"}, W'(data_wr), W'(0));
    checkOutput({tag, "_data_addr"}, data_addr, W'(0));
    checkOutput({tag, "_data_out"}, data_out, W'(0));
  endtask

  initial begin
    int base;
    int wc;
    bit got;

    rst = 1'b1;
    m0_bus.req = 1'b0; m0_bus.wr = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0;
    m1_bus.req = 1'b0; m1_bus.wr = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] write then read on port 0");
    wc = wr_count;
    doAccess("m0_wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    checkOutput("m0_wr_10_count", W'(wr_count - wc), W'(1));
    checkOutput("m0_wr_10_addr", last_wr_addr, 32'h10);
    doAccess("m0_rd_10", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    $display("[TB] port 1 boundary accesses");
    wc = wr_count;
    doAccess("m1_rd_3fc", 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hFCFDFEFF);
    doAccess("m1_wr_12", 1'b1, 1'b1, 32'h12, 32'hCAFEF00D, 1'b1, 32'h0);
    doAccess("m1_wr_3fe", 1'b1, 1'b1, 32'h3FE, 32'h12345678, 1'b1, 32'h0);
    doAccess("m1_rd_400", 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0);
    checkOutput("m1_bad_wr_count", W'(wr_count - wc), W'(0));
    doAccess("m1_rd_3fc_again", 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hFCFDFEFF);

    $display("[TB] both ports requesting from reset");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) pushExp(1'b0, 1'b0, 32'hDEADBEEF);
      else            pushExp(1'b1, 1'b0, 32'h20212223);
    end
    base = ack_count;
    have_prev = 1'b0;
    spacing_on = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 40 && ack_count < base + 6; i++) begin
      @(negedge clk); #1;
    end
    if (ack_count < base + 6) reportTimeout("alternate_six");
    @(posedge clk); #1;
    releasePort(1'b1);
    for (int i = 0; i < 10 && ack_count < base + 7; i++) begin
      @(negedge clk); #1;
    end
    if (ack_count < base + 7) reportTimeout("alternate_last");
    @(posedge clk); #1;
    releasePort(1'b0);
    spacing_on = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] reset during write access");
    #1;
    wc = wr_count;
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h11223344);
    @(posedge clk); #1;
    rst = 1'b1;
    releasePort(1'b0);
    @(negedge clk);
    checkOutput("rst_access_data_wr", W'(data_wr), W'(0));
    @(posedge clk); #1;
    @(negedge clk);
    checkResetOutputs("rst_access");
    checkOutput("rst_access_wr_count", W'(wr_count - wc), W'(0));
    checkOutput("rst_access_mem", {mem[10'h40], mem[10'h41], mem[10'h42], mem[10'h43]},
                32'h40414243);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] port 0 holds req through ack");
    @(posedge clk); #1;
    pushExp(1'b0, 1'b0, 32'hDEADBEEF);
    pushExp(1'b0, 1'b0, 32'hDEADBEEF);
    base = cyc;
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
    waitAck(1'b0, got);
    if (!got) reportTimeout("hold_first");
    else checkOutput("hold_first_latency", W'(cyc - base), W'(2));
    @(negedge clk);
    checkOutput("hold_no_regrant_addr", data_addr, W'(0));
    @(negedge clk);
    checkOutput("hold_regrant_addr", data_addr, 32'h10);
    waitAck(1'b0, got);
    if (!got) reportTimeout("hold_second");
    else checkOutput("hold_second_latency", W'(cyc - base), W'(5));
    @(posedge clk); #1;
    releasePort(1'b0);

    repeat (6) @(posedge clk);
    checkOutput("pending_expected", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
